// File: rtl/gambit_arb_pkg.sv
// Shared types for the L1 bus arbiter: FSM states, master ids and the
// bundled request fields of one master port.
package gambit_arb_pkg;

  // Widest address the bundled request can carry; the top truncates to ABW.
  localparam int ARB_ABW_MAX = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  typedef struct packed {
    logic                   cyc;
    logic                   stb;
    logic [2:0]             cti;
    logic [1:0]             bte;
    logic [7:0]             sel;
    logic [ARB_ABW_MAX-1:0] adr;
    logic                   cl;
  } bus_req_t;

  // On a tie the master that was not served last wins.
  function automatic master_id_e tie_winner(input master_id_e rr_last);
    return (rr_last == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/gambit_bus_wdog.sv
// Bus watchdog: counts silent granted cycles, flags a one-cycle error when
// the count reaches TIMEOUT, and keeps a saturating tally of such errors.
module gambit_bus_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic        resp_i,
  output logic        err_o,
  output logic [15:0] cnt_o
);

  localparam logic [9:0] LIMIT = 10'(TIMEOUT);

  logic [9:0]  tick_q, tick_d, tick_inc;
  logic [15:0] cnt_q, cnt_d;

  // The current silent cycle is number tick_q+1; a real response in the
  // same cycle takes priority over the injected error.
  assign tick_inc = tick_q + 10'd1;
  assign err_o    = active_i & ~resp_i & (tick_inc == LIMIT);
  assign cnt_o    = cnt_q;

  // Next-state: clear when idle, on a response or after firing; tally saturates.
  always_comb begin
    tick_d = tick_inc;
    if (!active_i || resp_i || err_o) tick_d = 10'd0;
    cnt_d = cnt_q;
    if (err_o && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Counter state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tick_q <= 10'd0;
      cnt_q  <= 16'd0;
    end else begin
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gambit_l1_bus_arbiter.sv
// Two-master arbiter in front of the BIU burst port (M0 = I-cache,
// M1 = D-cache). Grants are registered and locked for the whole cycle,
// with one turnaround cycle between owners and a watchdog on hung bursts.
module gambit_l1_bus_arbiter
  import gambit_arb_pkg::*;
#(
  parameter int ABW     = 52,
  parameter int TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           m0_cyc_i,
  input  logic           m0_stb_i,
  input  logic [2:0]     m0_cti_i,
  input  logic [1:0]     m0_bte_i,
  input  logic [7:0]     m0_sel_i,
  input  logic [ABW-1:0] m0_adr_i,
  input  logic           m0_cl_i,
  input  logic           m1_cyc_i,
  input  logic           m1_stb_i,
  input  logic [2:0]     m1_cti_i,
  input  logic [1:0]     m1_bte_i,
  input  logic [7:0]     m1_sel_i,
  input  logic [ABW-1:0] m1_adr_i,
  input  logic           m1_cl_i,
  output logic           m0_ack_o,
  output logic           m0_err_o,
  output logic           m0_wrv_o,
  output logic           m0_rdv_o,
  output logic           m0_bok_o,
  output logic           m1_ack_o,
  output logic           m1_err_o,
  output logic           m1_wrv_o,
  output logic           m1_rdv_o,
  output logic           m1_bok_o,
  output logic [103:0]   dat_o,
  output logic           cyc_o,
  output logic           stb_o,
  output logic [2:0]     cti_o,
  output logic [1:0]     bte_o,
  output logic [7:0]     sel_o,
  output logic [ABW-1:0] adr_o,
  output logic           dcl_o,
  input  logic           ack_i,
  input  logic           err_i,
  input  logic           wrv_i,
  input  logic           rdv_i,
  input  logic           bok_i,
  input  logic [103:0]   dat_i,
  output logic [1:0]     gnt_o,
  output logic [15:0]    wdog_cnt_o
);

  arb_state_e state_q;
  master_id_e rr_last_q;
  logic [1:0] gnt_q;
  bus_req_t   req0, req1, req_sel;
  logic       resp_any, wdog_err;

  // Bundle each master's request and select the granted one (zero when idle).
  always_comb begin
    req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, cti: m0_cti_i, bte: m0_bte_i,
             sel: m0_sel_i, adr: ARB_ABW_MAX'(m0_adr_i), cl: m0_cl_i};
    req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, cti: m1_cti_i, bte: m1_bte_i,
             sel: m1_sel_i, adr: ARB_ABW_MAX'(m1_adr_i), cl: m1_cl_i};
    req_sel = '0;
    if (gnt_q[0]) req_sel = req0;
    else if (gnt_q[1]) req_sel = req1;
  end

  assign cyc_o = req_sel.cyc;
  assign stb_o = req_sel.stb;
  assign cti_o = req_sel.cti;
  assign bte_o = req_sel.bte;
  assign sel_o = req_sel.sel;
  assign adr_o = req_sel.adr[ABW-1:0];
  assign dcl_o = req_sel.cl;
  assign dat_o = dat_i;
  assign gnt_o = gnt_q;

  // Responses reach only the granted master; the watchdog error rides on err.
  assign resp_any = ack_i | err_i | wrv_i | rdv_i;
  assign m0_ack_o = gnt_q[0] & ack_i;
  assign m0_err_o = gnt_q[0] & (err_i | wdog_err);
  assign m0_wrv_o = gnt_q[0] & wrv_i;
  assign m0_rdv_o = gnt_q[0] & rdv_i;
  assign m0_bok_o = gnt_q[0] & bok_i;
  assign m1_ack_o = gnt_q[1] & ack_i;
  assign m1_err_o = gnt_q[1] & (err_i | wdog_err);
  assign m1_wrv_o = gnt_q[1] & wrv_i;
  assign m1_rdv_o = gnt_q[1] & rdv_i;
  assign m1_bok_o = gnt_q[1] & bok_i;

  gambit_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active_i(|gnt_q),
    .resp_i  (resp_any),
    .err_o   (wdog_err),
    .cnt_o   (wdog_cnt_o)
  );

  // Arbitration FSM with registered one-hot grant and round-robin memory.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ARB_IDLE;
      rr_last_q <= M1;
      gnt_q     <= 2'b00;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || tie_winner(rr_last_q) == M0)) begin
            state_q <= ARB_G0;
            gnt_q   <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= ARB_G1;
            gnt_q   <= 2'b10;
          end
        end
        ARB_G0: begin
          if (!m0_cyc_i) begin
            state_q   <= ARB_TURN;
            rr_last_q <= M0;
            gnt_q     <= 2'b00;
          end
        end
        ARB_G1: begin
          if (!m1_cyc_i) begin
            state_q   <= ARB_TURN;
            rr_last_q <= M1;
            gnt_q     <= 2'b00;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gambit_l1_bus_arbiter.sv
// Directed bench for gambit_l1_bus_arbiter: a per-cycle vector table for
// arbitration, routing and burst lock, then hand sequences for the
// watchdog and an asynchronous reset mid-burst.
module tb_gambit_l1_bus_arbiter;

  localparam int ABW = 52;
  localparam int TIMEOUT = 8;
  localparam logic [ABW-1:0] A0 = 52'hA_0000_1234_5678;
  localparam logic [ABW-1:0] A1 = 52'h5_FFFF_0000_ABC0;

  logic clk = 1'b0;
  logic rst_i;
  logic m0_cyc_i, m0_stb_i, m0_cl_i, m1_cyc_i, m1_stb_i, m1_cl_i;
  logic [2:0] m0_cti_i, m1_cti_i, cti_o;
  logic [1:0] m0_bte_i, m1_bte_i, bte_o;
  logic [7:0] m0_sel_i, m1_sel_i, sel_o;
  logic [ABW-1:0] m0_adr_i, m1_adr_i, adr_o;
  logic m0_ack_o, m0_err_o, m0_wrv_o, m0_rdv_o, m0_bok_o;
  logic m1_ack_o, m1_err_o, m1_wrv_o, m1_rdv_o, m1_bok_o;
  logic [103:0] dat_o, dat_i;
  logic cyc_o, stb_o, dcl_o;
  logic ack_i, err_i, wrv_i, rdv_i, bok_i;
  logic [1:0] gnt_o;
  logic [15:0] wdog_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gambit_l1_bus_arbiter #(.ABW(ABW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_cl_i(m0_cl_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_cl_i(m1_cl_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_wrv_o(m0_wrv_o), .m0_rdv_o(m0_rdv_o),
    .m0_bok_o(m0_bok_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_wrv_o(m1_wrv_o), .m1_rdv_o(m1_rdv_o),
    .m1_bok_o(m1_bok_o),
    .dat_o(dat_o), .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o), .bte_o(bte_o),
    .sel_o(sel_o), .adr_o(adr_o), .dcl_o(dcl_o),
    .ack_i(ack_i), .err_i(err_i), .wrv_i(wrv_i), .rdv_i(rdv_i), .bok_i(bok_i),
    .dat_i(dat_i), .gnt_o(gnt_o), .wdog_cnt_o(wdog_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: inputs change 1 ns after the edge, outputs are sampled 5 ns later.
  task automatic drv(input logic m0c, input logic m1c, input logic ack);
    @(posedge clk);
    #1;
    m0_cyc_i = m0c; m0_stb_i = m0c;
    m1_cyc_i = m1c; m1_stb_i = m1c;
    ack_i = ack;
    #4;
  endtask

  typedef struct {
    logic m0c, m1c, m0s, ack, bok;
    logic [1:0] gnt;
    logic cyc, stb, m0a, m1a, m0b;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    logic [ABW-1:0] exp_adr;
    logic [2:0] exp_cti;

    // m0c m1c m0s ack bok | gnt cyc stb m0a m1a m0b
    tbl.push_back('{0,0,0,0,0, 2'b00,0,0,0,0,0}); // idle
    tbl.push_back('{1,1,1,0,1, 2'b00,0,0,0,0,0}); // tie seen in IDLE
    tbl.push_back('{1,1,1,1,1, 2'b01,1,1,1,0,1}); // M0 wins first tie
    tbl.push_back('{1,1,1,1,1, 2'b01,1,1,1,0,1});
    tbl.push_back('{1,1,1,0,1, 2'b01,1,1,0,0,1});
    tbl.push_back('{1,1,1,1,1, 2'b01,1,1,1,0,1});
    tbl.push_back('{0,1,0,1,1, 2'b01,0,0,1,0,1}); // drop with final ack
    tbl.push_back('{0,1,0,1,1, 2'b00,0,0,0,0,0}); // TURN drops response
    tbl.push_back('{0,1,0,0,1, 2'b00,0,0,0,0,0}); // IDLE
    tbl.push_back('{1,1,1,1,1, 2'b10,1,1,0,1,0}); // M1 granted, m0 waits
    tbl.push_back('{1,1,1,1,1, 2'b10,1,1,0,1,0});
    tbl.push_back('{1,0,1,1,0, 2'b10,0,0,0,1,0}); // M1 drops
    tbl.push_back('{1,1,1,0,0, 2'b00,0,0,0,0,0}); // TURN
    tbl.push_back('{1,1,1,0,0, 2'b00,0,0,0,0,0}); // IDLE tie, rr_last=M1
    tbl.push_back('{1,1,1,1,1, 2'b01,1,1,1,0,1}); // third tie -> M0
    tbl.push_back('{1,1,0,0,0, 2'b01,1,0,0,0,0}); // stb low, bok=0
    tbl.push_back('{1,1,1,1,0, 2'b01,1,1,1,0,0});
    tbl.push_back('{1,1,0,0,0, 2'b01,1,0,0,0,0});
    tbl.push_back('{1,1,1,1,0, 2'b01,1,1,1,0,0});
    tbl.push_back('{0,1,0,0,0, 2'b01,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,0, 2'b00,0,0,0,0,0}); // TURN
    tbl.push_back('{0,0,0,0,0, 2'b00,0,0,0,0,0}); // IDLE

    rst_i = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = 3'b010; m0_bte_i = 2'b01;
    m0_sel_i = 8'hFF; m0_adr_i = A0; m0_cl_i = 1'b1;
    m1_cyc_i = 0; m1_stb_i = 0; m1_cti_i = 3'b111; m1_bte_i = 2'b10;
    m1_sel_i = 8'h0F; m1_adr_i = A1; m1_cl_i = 1'b0;
    ack_i = 1; err_i = 0; wrv_i = 0; rdv_i = 0; bok_i = 0;
    dat_i = 104'hDEAD_BEEF_0123_4567_89AB_CDEF_55;

    #12;
    chk("reset_gnt", 64'(gnt_o), 64'h0);
    chk("reset_cyc", 64'(cyc_o), 64'h0);
    chk("reset_wdog_cnt", 64'(wdog_cnt_o), 64'h0);
    chk("reset_m0_ack", 64'(m0_ack_o), 64'h0);
    chk("dat_passthru", 64'(dat_o[63:0]), 64'(dat_i[63:0]));
    ack_i = 0;
    #10;
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s;
      m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1c;
      ack_i = tbl[i].ack; bok_i = tbl[i].bok;
      #4;
      exp_adr = (tbl[i].gnt == 2'b01) ? A0 : (tbl[i].gnt == 2'b10) ? A1 : '0;
      exp_cti = (tbl[i].gnt == 2'b01) ? 3'b010 : (tbl[i].gnt == 2'b10) ? 3'b111 : 3'b000;
      chk($sformatf("vec%0d_gnt", i), 64'(gnt_o), 64'(tbl[i].gnt));
      chk($sformatf("vec%0d_cyc", i), 64'(cyc_o), 64'(tbl[i].cyc));
      chk($sformatf("vec%0d_stb", i), 64'(stb_o), 64'(tbl[i].stb));
      chk($sformatf("vec%0d_m0_ack", i), 64'(m0_ack_o), 64'(tbl[i].m0a));
      chk($sformatf("vec%0d_m1_ack", i), 64'(m1_ack_o), 64'(tbl[i].m1a));
      chk($sformatf("vec%0d_m0_bok", i), 64'(m0_bok_o), 64'(tbl[i].m0b));
      chk($sformatf("vec%0d_adr", i), 64'(adr_o), 64'(exp_adr));
      chk($sformatf("vec%0d_cti", i), 64'(cti_o), 64'(exp_cti));
      $display("vec %0d: gnt=%b cyc=%b stb=%b m0_ack=%b m1_ack=%b m0_bok=%b",
               i, gnt_o, cyc_o, stb_o, m0_ack_o, m1_ack_o, m0_bok_o);
    end
    bok_i = 0;

    // Watchdog: eight silent granted cycles raise a single err to M0.
    drv(1, 0, 0);
    chk("wd_idle_gnt", 64'(gnt_o), 64'h0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      drv(1, 0, 0);
      chk($sformatf("wd_silent%0d_gnt", k), 64'(gnt_o), 64'h1);
      chk($sformatf("wd_silent%0d_err", k), 64'(m0_err_o), 64'(k == TIMEOUT));
      chk($sformatf("wd_silent%0d_m1_err", k), 64'(m1_err_o), 64'h0);
    end
    drv(0, 0, 0);
    chk("wd_cnt_after_err", 64'(wdog_cnt_o), 64'h1);
    chk("wd_after_err_err", 64'(m0_err_o), 64'h0);
    $display("watchdog timeout: wdog_cnt=%0d", wdog_cnt_o);
    drv(0, 0, 0);
    drv(0, 0, 0);

    // Ack on the eighth silent cycle beats the watchdog.
    drv(1, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) drv(1, 0, 0);
    drv(1, 0, 1);
    chk("wd_race_err", 64'(m0_err_o), 64'h0);
    chk("wd_race_ack", 64'(m0_ack_o), 64'h1);
    drv(0, 0, 0);
    chk("wd_race_cnt", 64'(wdog_cnt_o), 64'h1);
    $display("watchdog race: err=0 expected, wdog_cnt=%0d", wdog_cnt_o);
    drv(0, 0, 0);
    drv(0, 0, 0);

    // Asynchronous reset in the middle of an M1 burst.
    drv(0, 1, 0);
    drv(0, 1, 1);
    chk("rst_pre_gnt", 64'(gnt_o), 64'h2);
    chk("rst_pre_m1_ack", 64'(m1_ack_o), 64'h1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_cyc", 64'(cyc_o), 64'h0);
    chk("rst_mid_stb", 64'(stb_o), 64'h0);
    chk("rst_mid_m1_ack", 64'(m1_ack_o), 64'h0);
    chk("rst_mid_gnt", 64'(gnt_o), 64'h0);
    chk("rst_mid_wdog_cnt", 64'(wdog_cnt_o), 64'h0);
    $display("reset mid-burst: cyc=%b stb=%b m1_ack=%b", cyc_o, stb_o, m1_ack_o);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; ack_i = 0;
    #1;
    rst_i = 1'b1;
    drv(1, 1, 0);
    chk("post_rst_idle_gnt", 64'(gnt_o), 64'h0);
    drv(1, 1, 1);
    chk("post_rst_tie_gnt", 64'(gnt_o), 64'h1);
    chk("post_rst_m0_ack", 64'(m0_ack_o), 64'h1);
    chk("post_rst_m1_ack", 64'(m1_ack_o), 64'h0);
    $display("post reset tie: gnt=%b", gnt_o);
    drv(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
